// File: rtl/spi_master.sv
// Mode-0 SPI master: sends one DATA_W-bit word per start and captures the reply.
// Define SPI_LSB_FIRST_EN to shift LSB first in both directions; MSB first otherwise.
module spi_master #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              ss_m,
    output logic              sclk_m,
    output logic              mosi_m,
    input  logic              miso_m
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BITS     = BW'(DATA_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

`ifdef SPI_LSB_FIRST_EN
    function automatic logic tx_head(input logic [DATA_W-1:0] v);
        return v[0];
    endfunction

    function automatic logic [DATA_W-1:0] tx_next(input logic [DATA_W-1:0] v);
        return {1'b0, v[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] rx_next(input logic [DATA_W-1:0] v, input logic b);
        return {b, v[DATA_W-1:1]};
    endfunction
`else
    function automatic logic tx_head(input logic [DATA_W-1:0] v);
        return v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] tx_next(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_W-1:0] rx_next(input logic [DATA_W-1:0] v, input logic b);
        return {v[DATA_W-2:0], b};
    endfunction
`endif

    state_t            state_q;
    logic [DATA_W-1:0] tx_sr_q;
    logic [DATA_W-1:0] rx_sr_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [CW-1:0]     div_cnt_q;
    logic              ss_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              busy_q;
    logic              done_q;

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign ss_m    = ss_q;
    assign sclk_m  = sclk_q;
    assign mosi_m  = mosi_q;

    // Pin-facing flags (ss, busy, done) update on the edge where their state is processed,
    // so they trail the state register by one cycle; sclk/mosi/miso move with the shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            ss_q      <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ss_q   <= 1'b1;
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        tx_sr_q   <= tx_data;
                        bit_cnt_q <= '0;
                        div_cnt_q <= '0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    ss_q   <= 1'b0;
                    busy_q <= 1'b1;
                    sclk_q <= 1'b0;
                    mosi_q <= tx_head(tx_sr_q);
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        sclk_q    <= ~sclk_q;
                        if (!sclk_q) begin
                            rx_sr_q   <= rx_next(rx_sr_q, miso_m);
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else if (bit_cnt_q == BITS) begin
                            state_q <= HOLD;
                        end else begin
                            tx_sr_q <= tx_next(tx_sr_q);
                            mosi_q  <= tx_head(tx_next(tx_sr_q));
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    sclk_q <= 1'b0;
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        state_q   <= DONE;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    ss_q      <= 1'b1;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    mosi_q    <= 1'b0;
                    sclk_q    <= 1'b0;
                    rx_data_q <= rx_sr_q;
                    state_q   <= IDLE;
                end
                default: begin
                    ss_q      <= 1'b1;
                    sclk_q    <= 1'b0;
                    mosi_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    div_cnt_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (DATA_W=16, CLK_DIV=4): loopback and slave-model frames.
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] tx_data = 16'h0000;
    logic        busy, done, ss_m, sclk_m, mosi_m;
    logic [15:0] rx_data;
    logic        miso_s;
    logic        mode_slave = 1'b0;
    logic [15:0] slave_pat = 16'h0000;

    int n_vec = 0;
    int n_miss = 0;
    int rise_tot = 0;
    int fall_cnt = 0;
    int done_cnt = 0;
    int ss_glitch = 0;
    int mosi_hi = 0;

    spi_master #(.DATA_W(16), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .ss_m(ss_m), .sclk_m(sclk_m), .mosi_m(mosi_m), .miso_m(miso_s)
    );

    always #5 clk = ~clk;

    // Slave model: presents bit 15 on select, then advances one bit per sclk falling edge.
    always @(negedge sclk_m or posedge ss_m) begin
        if (ss_m) fall_cnt <= 0;
        else      fall_cnt <= fall_cnt + 1;
    end

    always_comb begin
        miso_s = mosi_m;
        if (mode_slave) miso_s = (fall_cnt < 16) ? slave_pat[15 - fall_cnt] : 1'b0;
    end

    always @(posedge sclk_m) rise_tot <= rise_tot + 1;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (busy && ss_m) ss_glitch <= ss_glitch + 1;
        if (busy && mosi_m) mosi_hi <= mosi_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Counts clk edges until done is seen (#1 after the edge), bounded.
    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 2000);
        if (!done) check(tag, 32'd0, 32'd1);
    endtask

    task automatic launch(input logic [15:0] w);
        @(negedge clk);
        start   = 1'b1;
        tx_data = w;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic ss_gap(output int gap);
        gap = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (ss_m) gap++;
            else break;
        end
    endtask

    initial begin
        int cyc, base, dc, g0, m0, gap;
        logic [15:0] exp_slave;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ss", {31'd0, ss_m}, 32'd1);
        check("rst_sclk", {31'd0, sclk_m}, 32'd0);
        check("rst_mosi", {31'd0, mosi_m}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rx", {16'd0, rx_data}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: loopback 7777
        base = rise_tot; g0 = ss_glitch;
        launch(16'h7777);
        check("t1_ss_accept_edge", {31'd0, ss_m}, 32'd1);
        tx_data = 16'h0000;
        @(posedge clk); #1;
        check("t1_busy_next", {31'd0, busy}, 32'd1);
        check("t1_ss_next", {31'd0, ss_m}, 32'd0);
        wait_done("t1_timeout", cyc);
        check("t1_latency", cyc + 1, 32'd137);
        check("t1_rx", {16'd0, rx_data}, 32'h7777);
        check("t1_rises", rise_tot - base, 32'd16);
        check("t1_ss_low", ss_glitch - g0, 32'd0);
        @(posedge clk); #1;
        check("t1_done_pulse", {31'd0, done}, 32'd0);

        // 2: slave drives A5C3, tx all zeros
`ifdef SPI_LSB_FIRST_EN
        exp_slave = 16'hC3A5;
`else
        exp_slave = 16'hA5C3;
`endif
        repeat (3) @(negedge clk);
        mode_slave = 1'b1; slave_pat = 16'hA5C3; m0 = mosi_hi;
        launch(16'h0000);
        wait_done("t2_timeout", cyc);
        check("t2_rx", {16'd0, rx_data}, {16'd0, exp_slave});
        check("t2_mosi_low", mosi_hi - m0, 32'd0);
        mode_slave = 1'b0;

        // 3: start pulse mid-frame is ignored
        repeat (3) @(negedge clk);
        dc = done_cnt;
        launch(16'h1234);
        repeat (39) @(posedge clk);
        @(negedge clk);
        start = 1'b1; tx_data = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0; tx_data = 16'h0000;
        wait_done("t3_timeout", cyc);
        check("t3_latency", cyc, 32'd97);
        check("t3_rx", {16'd0, rx_data}, 32'h1234);
        repeat (300) @(posedge clk);
        check("t3_single_done", done_cnt - dc, 32'd1);

        // 4: reset after the 5th rising sclk edge
        @(negedge clk);
        base = rise_tot; dc = done_cnt;
        launch(16'h7777);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rise_tot - base >= 5) break;
        end
        check("t4_reached_5", (rise_tot - base >= 5) ? 32'd1 : 32'd0, 32'd1);
        rst = 1'b1;
        #1;
        check("t4_ss", {31'd0, ss_m}, 32'd1);
        check("t4_sclk", {31'd0, sclk_m}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_rx", {16'd0, rx_data}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("t4_no_done", done_cnt - dc, 32'd0);
        launch(16'h0F0F);
        wait_done("t4b_timeout", cyc);
        check("t4b_latency", cyc, 32'd137);
        check("t4b_rx", {16'd0, rx_data}, 32'h0F0F);

        // 5: start held high for three back-to-back frames
        repeat (3) @(negedge clk);
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1; tx_data = 16'h0001;
        @(posedge clk); #1;
        tx_data = 16'h8000;
        wait_done("t5a_timeout", cyc);
        check("t5a_latency", cyc, 32'd137);
        check("t5a_rx", {16'd0, rx_data}, 32'h0001);
        ss_gap(gap);
        check("t5a_gap", gap, 32'd2);
        tx_data = 16'hFFFF;
        wait_done("t5b_timeout", cyc);
        check("t5b_latency", cyc, 32'd136);
        check("t5b_rx", {16'd0, rx_data}, 32'h8000);
        ss_gap(gap);
        check("t5b_gap", gap, 32'd2);
        start = 1'b0;
        tx_data = 16'h0000;
        wait_done("t5c_timeout", cyc);
        check("t5c_rx", {16'd0, rx_data}, 32'hFFFF);
        repeat (300) @(posedge clk);
        #1;
        check("t5_done_count", done_cnt - dc, 32'd3);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        check("t5_idle_ss", {31'd0, ss_m}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
